spi_io_ctrl: RTL



---
 rtl/spi_io_ctrl.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_io_ctrl.sv
// -----------------------------------------------------------------------------
// spi_io_ctrl
// I/O-space SPI master for the PCMCIA card. The host runs byte-wide SPI
// transfers through four registers in PCMCIA I/O space:
//   A[1:0] = 0 DATA    write: load TX byte and start; read: RX byte
//   A[1:0] = 1 CTRL    write: bit0 CS, bit1 IEN
//                      read:  bit0 CS, bit1 IEN, bit4 BUSY, bit5 DONE, bit6 OVR
//   A[1:0] = 2 DIV     SCLK half-period is DIV+1 clk_26 cycles
//   A[1:0] = 3 ID      read-only 8'h5A
//
// Ports
//   clk_26, RESET           system clock, async active-high reset
//   A, D_in                 host address / write data
//   D_out, DDIR             read data and drive enable (0 when not selected)
//   CE1, REG, IOWR, IORD    PCMCIA strobes, active-low
//   SS, SCLK, MOSI, MISO    SPI mode 0, MSB first; SS follows CS only
//   INT                     level interrupt, IEN & DONE
//
// Build option
//   SPI_IRQ_EN  when defined, implements IEN and a registered INT output;
//               when undefined, IEN reads 0 and INT is tied 0.
// -----------------------------------------------------------------------------
module spi_io_ctrl #(
  parameter logic [15:0] IO_BASE = 16'h0100,
  parameter logic [7:0]  DIV_RST = 8'd12
) (
  input  logic        clk_26,
  input  logic        RESET,
  input  logic [15:0] A,
  input  logic [7:0]  D_in,
  output logic [7:0]  D_out,
  output logic        DDIR,
  input  logic        CE1,
  input  logic        REG,
  input  logic        IOWR,
  input  logic        IORD,
  output logic        SS,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO,
  output logic        INT
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_DONE
  } state_e;

  localparam logic [7:0] ID_VALUE = 8'h5A;

  // Strobe synchronizers: [0] first stage, [1] synchronized, [2] previous
  // synchronized value for edge detection.
  logic [2:0] iowr_sync_q, iowr_sync_d;
  logic [2:0] iord_sync_q, iord_sync_d;
  logic       rd_sel_q, rd_sel_d;
  logic [1:0] rd_idx_q, rd_idx_d;

  state_e     state_q, state_d;
  logic       cs_q, cs_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       ovr_q, ovr_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] div_q, div_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] half_q, half_d;
  logic       sclk_q, sclk_d;
  logic       mosi_q, mosi_d;
  logic       ien;

`ifdef SPI_IRQ_EN
  logic       ien_q, ien_d;
  logic       int_q, int_d;
  assign ien = ien_q;
  assign INT = int_q;
`else
  assign ien = 1'b0;
  assign INT = 1'b0;
`endif

  logic       sel;
  logic       wr_fire;
  logic       data_wr;
  logic       rd_fall;
  logic       rd_rise;
  logic [7:0] status;
  logic [7:0] reg_rd;

  assign sel     = !CE1 && !REG && (A[15:2] == IO_BASE[15:2]);
  assign wr_fire = sel && !iowr_sync_q[1] && iowr_sync_q[2];
  assign data_wr = wr_fire && (A[1:0] == 2'd0);
  assign rd_fall = !iord_sync_q[1] && iord_sync_q[2];
  assign rd_rise = iord_sync_q[1] && !iord_sync_q[2];
  assign status  = {1'b0, ovr_q, done_q, busy_q, 2'b00, ien, cs_q};

  // Host read path is purely combinational on the raw strobe.
  always_comb begin
    case (A[1:0])
      2'd0:    reg_rd = rx_q;
      2'd1:    reg_rd = status;
      2'd2:    reg_rd = div_q;
      default: reg_rd = ID_VALUE;
    endcase
    DDIR  = sel && !IORD;
    D_out = DDIR ? reg_rd : 8'h00;
  end

  assign SS   = !cs_q;
  assign SCLK = sclk_q;
  assign MOSI = mosi_q;

  always_comb begin
    // NOTE: every _d starts as its _q so no path through this block can
    // leave a signal unassigned and infer a latch.
    iowr_sync_d = {iowr_sync_q[1:0], IOWR};
    iord_sync_d = {iord_sync_q[1:0], IORD};
    rd_sel_d    = rd_sel_q;
    rd_idx_d    = rd_idx_q;
    state_d     = state_q;
    cs_d        = cs_q;
    busy_d      = busy_q;
    done_d      = done_q;
    ovr_d       = ovr_q;
    rx_d        = rx_q;
    div_d       = div_q;
    shift_d     = shift_q;
    bit_d       = bit_q;
    cnt_d       = cnt_q;
    half_d      = half_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
`ifdef SPI_IRQ_EN
    ien_d       = ien_q;
    int_d       = ien_q & done_q;
`endif

    // Read side effects use the address captured when the read began.
    if (rd_fall) begin
      rd_sel_d = sel;
      rd_idx_d = A[1:0];
    end
    if (rd_rise && rd_sel_q) begin
      if (rd_idx_q == 2'd0) done_d = 1'b0;
      if (rd_idx_q == 2'd1) ovr_d  = 1'b0;
    end

    // Host writes; placed after the clears so a same-cycle OVR set wins.
    if (wr_fire) begin
      case (A[1:0])
        2'd0: if (busy_q) ovr_d = 1'b1;
        2'd1: begin
          cs_d = D_in[0];
`ifdef SPI_IRQ_EN
          ien_d = D_in[1];
`endif
        end
        2'd2: div_d = D_in;
        default: ;
      endcase
    end

    // Half-period length is reloaded from DIV only at phase boundaries, so a
    // DIV write mid-transfer never stretches or cuts the current phase.
    case (state_q)
      ST_IDLE: begin
        if (data_wr) begin
          shift_d = D_in;
          mosi_d  = D_in[7];
          busy_d  = 1'b1;
          done_d  = 1'b0;
          bit_d   = 3'd0;
          cnt_d   = 8'd0;
          half_d  = div_q;
          sclk_d  = 1'b0;
          state_d = ST_LOW;
        end
      end
      ST_LOW: begin
        if (cnt_q == half_q) begin
          cnt_d   = 8'd0;
          half_d  = div_q;
          sclk_d  = 1'b1;
          state_d = ST_HIGH;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_HIGH: begin
        if (cnt_q == half_q) begin
          shift_d = {shift_q[6:0], MISO};
          mosi_d  = shift_q[6];
          cnt_d   = 8'd0;
          half_d  = div_q;
          sclk_d  = 1'b0;
          if (bit_q == 3'd7) begin
            state_d = ST_DONE;
          end else begin
            bit_d   = bit_q + 3'd1;
            state_d = ST_LOW;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DONE: begin
        // Comes after the read clear above, so DONE set beats DONE clear.
        rx_d    = shift_q;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        sclk_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state is updated only with non-blocking assignments so every flop
  // samples its _d from the same pre-edge values.
  always_ff @(posedge clk_26 or posedge RESET) begin
    if (RESET) begin
      iowr_sync_q <= 3'b111;
      iord_sync_q <= 3'b111;
      rd_sel_q    <= 1'b0;
      rd_idx_q    <= 2'd0;
      state_q     <= ST_IDLE;
      cs_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovr_q       <= 1'b0;
      rx_q        <= 8'h00;
      div_q       <= DIV_RST;
      shift_q     <= 8'h00;
      bit_q       <= 3'd0;
      cnt_q       <= 8'd0;
      half_q      <= 8'd0;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
`ifdef SPI_IRQ_EN
      ien_q       <= 1'b0;
      int_q       <= 1'b0;
`endif
    end else begin
      iowr_sync_q <= iowr_sync_d;
      iord_sync_q <= iord_sync_d;
      rd_sel_q    <= rd_sel_d;
      rd_idx_q    <= rd_idx_d;
      state_q     <= state_d;
      cs_q        <= cs_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ovr_q       <= ovr_d;
      rx_q        <= rx_d;
      div_q       <= div_d;
      shift_q     <= shift_d;
      bit_q       <= bit_d;
      cnt_q       <= cnt_d;
      half_q      <= half_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
`ifdef SPI_IRQ_EN
      ien_q       <= ien_d;
      int_q       <= int_d;
`endif
    end
  end

endmodule
